// File: rtl/banked_bus_memory.sv
// banked_bus_memory: NUM_PORTS toggle-handshake requesters share one word-wide RAM
// through a round-robin arbiter. Supports word/byte access, programmable wait
// states and an out-of-range error flag.
module banked_bus_memory #(
  parameter int    NUM_PORTS   = 2,
  parameter int    DATA_W      = 16,
  parameter int    ADDR_W      = 16,
  parameter int    DEPTH_WORDS = 32768,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [2*NUM_PORTS-1:0]      cmd,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [NUM_PORTS-1:0]        run,
  input  logic [DATA_W*NUM_PORTS-1:0] wr_data,
  output logic [DATA_W*NUM_PORTS-1:0] rd_data,
  output logic [NUM_PORTS-1:0]        done,
  output logic [NUM_PORTS-1:0]        err
);

  localparam int NB = DATA_W / 8;
  localparam int BI = $clog2(NB);
  localparam int BW = (BI > 0) ? BI : 1;
  localparam int MW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [3:0]          wcnt;
  logic [PW-1:0]       l_port;
  logic [1:0]          l_cmd;
  logic [ADDR_W-1:0]   l_addr;
  logic [DATA_W-1:0]   l_wdata;

  logic [DATA_W-1:0]   mem [DEPTH_WORDS];

  logic [NUM_PORTS-1:0] pend;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_port;
  logic [ADDR_W-1:0]    widx;
  logic [MW-1:0]        midx;
  logic [BW-1:0]        lane;
  logic                 in_range;
  logic [DATA_W-1:0]    mem_word;
  logic [7:0]           mem_byte;

  // A request is outstanding whenever the port's toggle differs from its completion toggle.
  assign pend     = run ^ done;
  assign widx     = l_addr >> BI;
  assign midx     = widx[MW-1:0];
  assign lane     = (NB > 1) ? l_addr[BW-1:0] : '0;
  assign in_range = (32'(widx) < 32'(DEPTH_WORDS));
  assign mem_word = mem[midx];
  assign mem_byte = mem_word[{lane, 3'b000} +: 8];

  // Round-robin pick: first pending port at or after rr_ptr, with wrap-around.
  // The loop runs downward so the smallest offset from rr_ptr is assigned last and wins.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_port = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (pend[idx]) begin
        gnt_vld  = 1'b1;
        gnt_port = PW'(idx);
      end
    end
  end

  // Control FSM: grant and latch request, optional wait count, then access and completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      wcnt    <= '0;
      done    <= '0;
      err     <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_vld) begin
            l_port  <= gnt_port;
            l_cmd   <= cmd[2*gnt_port +: 2];
            l_addr  <= addr[ADDR_W*gnt_port +: ADDR_W];
            l_wdata <= wr_data[DATA_W*gnt_port +: DATA_W];
            rr_ptr  <= PW'((int'(gnt_port) + 1) % NUM_PORTS);
            wcnt    <= '0;
            state   <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (wcnt == 4'(WAIT_STATES - 1)) state <= S_ACCESS;
          else                             wcnt  <= wcnt + 4'd1;
        end
        S_ACCESS: begin
          done[l_port] <= ~done[l_port];
          if (!in_range) begin
            err[l_port] <= 1'b1;
            if (!l_cmd[0]) rd_data[DATA_W*l_port +: DATA_W] <= '0;
          end else begin
            err[l_port] <= 1'b0;
            if (!l_cmd[0])
              rd_data[DATA_W*l_port +: DATA_W] <= l_cmd[1] ? DATA_W'(mem_byte) : mem_word;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM write port: commits only in ACCESS, never while reset is asserted, never out of range.
  always_ff @(posedge clk) begin
    if (reset_n && state == S_ACCESS && l_cmd[0] && in_range) begin
      if (l_cmd[1]) mem[midx][{lane, 3'b000} +: 8] <= l_wdata[7:0];
      else          mem[midx] <= l_wdata;
    end
  end

endmodule

// File: tb/tb_banked_bus_memory.sv
// Bench for banked_bus_memory: instance A (no wait states) and instance B
// (three wait states), both with a 1024-word RAM, checked against a byte-array model.
module tb_banked_bus_memory;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  cmd_a, cmd_b;
  logic [31:0] addr_a, addr_b, wd_a, wd_b, rd_a, rd_b;
  logic [1:0]  run_a, run_b, done_a, done_b, err_a, err_b;

  banked_bus_memory #(.NUM_PORTS(2), .DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(DEPTH),
                      .WAIT_STATES(0), .INIT_FILE("")) dut_a (
    .clk(clk), .reset_n(rst_a), .cmd(cmd_a), .addr(addr_a), .run(run_a),
    .wr_data(wd_a), .rd_data(rd_a), .done(done_a), .err(err_a));

  banked_bus_memory #(.NUM_PORTS(2), .DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(DEPTH),
                      .WAIT_STATES(3), .INIT_FILE("")) dut_b (
    .clk(clk), .reset_n(rst_b), .cmd(cmd_b), .addr(addr_b), .run(run_b),
    .wr_data(wd_b), .rd_data(rd_b), .done(done_b), .err(err_b));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: RAM as little-endian bytes, per-port read data and error flags.
  logic [7:0]  mb   [2][2*DEPTH];
  logic [15:0] rd_m [2][2];
  logic        err_m[2][2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int d, input int p);
    return (d == 0) ? done_a[p] : done_b[p];
  endfunction
  function automatic logic err_of(input int d, input int p);
    return (d == 0) ? err_a[p] : err_b[p];
  endfunction
  function automatic logic [15:0] rd_of(input int d, input int p);
    return (d == 0) ? rd_a[16*p +: 16] : rd_b[16*p +: 16];
  endfunction

  task automatic model(input int d, input int p, input logic [1:0] c,
                       input logic [15:0] a, input logic [15:0] wd);
    int w;
    w = int'(a) / 2;
    if (w >= DEPTH) begin
      err_m[d][p] = 1'b1;
      if (!c[0]) rd_m[d][p] = 16'h0000;
    end else begin
      err_m[d][p] = 1'b0;
      case (c)
        2'b00: rd_m[d][p] = {mb[d][2*w+1], mb[d][2*w]};
        2'b01: begin mb[d][2*w] = wd[7:0]; mb[d][2*w+1] = wd[15:8]; end
        2'b10: rd_m[d][p] = {8'h00, mb[d][int'(a)]};
        default: mb[d][int'(a)] = wd[7:0];
      endcase
    end
  endtask

  // One uncontended request; inputs are scrambled after the grant edge.
  task automatic access(input int d, input int p, input logic [1:0] c,
                        input logic [15:0] a, input logic [15:0] wd, input string tag);
    logic dprev;
    int   n;
    int   exp_lat;
    exp_lat = (d == 0) ? 2 : 5;
    dprev   = done_of(d, p);
    if (d == 0) begin
      cmd_a[2*p +: 2] = c; addr_a[16*p +: 16] = a; wd_a[16*p +: 16] = wd; run_a[p] = ~run_a[p];
    end else begin
      cmd_b[2*p +: 2] = c; addr_b[16*p +: 16] = a; wd_b[16*p +: 16] = wd; run_b[p] = ~run_b[p];
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (d == 0) begin
          cmd_a[2*p +: 2] = 2'($urandom); addr_a[16*p +: 16] = 16'($urandom); wd_a[16*p +: 16] = 16'($urandom);
        end else begin
          cmd_b[2*p +: 2] = 2'($urandom); addr_b[16*p +: 16] = 16'($urandom); wd_b[16*p +: 16] = 16'($urandom);
        end
      end
    end while (done_of(d, p) === dprev && n < 20);
    model(d, p, c, a, wd);
    check({tag, "_lat"},   32'(n), 32'(exp_lat));
    check({tag, "_rd"},    32'(rd_of(d, p)), 32'(rd_m[d][p]));
    check({tag, "_err"},   32'(err_of(d, p)), 32'(err_m[d][p]));
    check({tag, "_other"}, 32'(rd_of(d, 1 - p)), 32'(rd_m[d][1 - p]));
  endtask

  initial begin
    int t0, t1, t0b;
    logic d0, d1;
    logic [1:0]  rc;
    logic [15:0] ra, rw;

    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin rd_m[d][p] = '0; err_m[d][p] = 1'b0; end

    // T1: reset with both run bits held high; port0 then port1 served after release
    rst_a = 1'b0; rst_b = 1'b0;
    run_a = 2'b11; cmd_a = 4'b0101; addr_a = {16'h0020, 16'h0010}; wd_a = {16'h2222, 16'h1111};
    run_b = 2'b00; cmd_b = '0; addr_b = '0; wd_b = '0;
    repeat (3) @(negedge clk);
    check("t1_done",   32'(done_a), 32'h0);
    check("t1_err",    32'(err_a),  32'h0);
    check("t1_rd",     rd_a,        32'h0);
    check("t1_done_b", 32'(done_b), 32'h0);
    rst_a = 1'b1; rst_b = 1'b1;
    t0 = 0; t1 = 0; d0 = done_a[0]; d1 = done_a[1];
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done_a[0] !== d0 && t0 == 0) begin d0 = done_a[0]; t0 = n; end
      if (done_a[1] !== d1 && t1 == 0) begin d1 = done_a[1]; t1 = n; end
    end
    model(0, 0, 2'b01, 16'h0010, 16'h1111);
    model(0, 1, 2'b01, 16'h0020, 16'h2222);
    check("t1_p0_first", 32'(t0), 32'd2);
    check("t1_p1_next",  32'(t1), 32'd4);

    // T4: simultaneous toggles with rr_ptr=0, then port0 re-requests right after its completion
    cmd_a = 4'b0000; addr_a = {16'h0010, 16'h0020};
    run_a = ~run_a;
    t0 = 0; t1 = 0; t0b = 0; d0 = done_a[0]; d1 = done_a[1];
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done_a[0] !== d0) begin
        d0 = done_a[0];
        if (t0 == 0) begin
          t0 = n;
          check("t4_p0_rd", 32'(rd_a[15:0]), 32'(16'h2222));
          addr_a[15:0] = 16'h0010;
          run_a[0] = ~run_a[0];
        end else if (t0b == 0) t0b = n;
      end
      if (done_a[1] !== d1 && t1 == 0) begin d1 = done_a[1]; t1 = n; end
    end
    model(0, 0, 2'b00, 16'h0020, 16'h0);
    model(0, 1, 2'b00, 16'h0010, 16'h0);
    model(0, 0, 2'b00, 16'h0010, 16'h0);
    check("t4_p0_lat",     32'(t0),  32'd2);
    check("t4_p1_lat",     32'(t1),  32'd4);
    check("t4_p0_again",   32'(t0b), 32'd6);
    check("t4_p1_rd",      32'(rd_a[31:16]), 32'(rd_m[0][1]));
    check("t4_p0_rd2",     32'(rd_a[15:0]),  32'(rd_m[0][0]));

    // Fill the low 64 words so later reads have defined contents
    for (int w = 0; w < 64; w++)
      access(0, w % 2, 2'b01, 16'(2 * w), 16'($urandom), "fill");

    // T2: word write/read
    access(0, 0, 2'b01, 16'h0040, 16'hBEEF, "t2_wr");
    access(0, 0, 2'b00, 16'h0040, 16'h0000, "t2_rd");
    check("t2_beef", 32'(rd_a[15:0]), 32'(16'hBEEF));

    // T3: byte lanes
    access(0, 0, 2'b01, 16'h0040, 16'h1234, "t3_wr");
    access(0, 1, 2'b11, 16'h0041, 16'h00AB, "t3_bwr");
    access(0, 0, 2'b00, 16'h0040, 16'h0000, "t3_rd");
    check("t3_word", 32'(rd_a[15:0]), 32'(16'hAB34));
    access(0, 1, 2'b10, 16'h0040, 16'h0000, "t3_brd");
    check("t3_byte", 32'(rd_a[31:16]), 32'(16'h0034));

    // T6: out-of-range write sets err and leaves word 0 alone; next valid read clears err
    access(0, 0, 2'b01, 16'h0800, 16'hDEAD, "t6_wr");
    check("t6_err_set", 32'(err_a[0]), 32'd1);
    access(0, 0, 2'b00, 16'h0000, 16'h0000, "t6_rd");
    check("t6_err_clr", 32'(err_a[0]), 32'd0);

    // Randomized mix of ports, commands and in/out-of-range addresses
    for (int i = 0; i < 60; i++) begin
      rc = 2'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0800, 16'hFFFF))
                                       : 16'($urandom_range(0, 127));
      rw = 16'($urandom);
      access(0, int'($urandom_range(0, 1)), rc, ra, rw, "rnd");
    end

    // T5: wait states on instance B, then reset during WAIT discards the pending write
    access(1, 0, 2'b01, 16'h0010, 16'h5A5A, "t5_wr");
    access(1, 0, 2'b00, 16'h0010, 16'h0000, "t5_rd");
    check("t5_data", 32'(rd_b[15:0]), 32'(16'h5A5A));
    cmd_b[1:0] = 2'b01; addr_b[15:0] = 16'h0010; wd_b[15:0] = 16'hDEAD;
    run_b[0] = ~run_b[0];
    @(negedge clk);
    rst_b = 1'b0; run_b[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_rst_done", 32'(done_b), 32'h0);
    check("t5_rst_rd",   rd_b,        32'h0);
    check("t5_rst_err",  32'(err_b),  32'h0);
    rd_m[1][0] = '0; rd_m[1][1] = '0; err_m[1][0] = 1'b0; err_m[1][1] = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    access(1, 0, 2'b00, 16'h0010, 16'h0000, "t5_after");
    check("t5_kept", 32'(rd_b[15:0]), 32'(16'h5A5A));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
